ifetch_unit: RTL and testbench

//  Consumer side of the pc register interface. Takes the current PC (pc.o_pc),

---
 rtl/ifetch_unit_pkg.sv | 23 ++
 rtl/ifetch_unit_if.sv | 32 +++
 rtl/ifetch_unit_inst_buf.sv | 51 +++++
 rtl/ifetch_unit.sv | 151 +++++++++++++++
 tb/tb_ifetch_unit.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_unit_pkg
// Shared definitions for the instruction fetch unit: FSM state encoding,
// PC increment, reset value of the instruction buffer and a small helper
// for redirect alignment checks.
// ----------------------------------------------------------------------------
package ifetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_INC = 4;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    // A redirect target is word-aligned only when its two LSBs are zero.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// ----------------------------------------------------------------------------
// ifetch_unit_if
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
//   req   : fetch request, held until ack
//   addr  : word address of the request
//   ack   : read data valid, single-cycle pulse
//   rdata : instruction word, valid while ack
// Modports: master = fetch unit, slave = instruction memory.
// ----------------------------------------------------------------------------
interface ifetch_unit_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic [AW-1:0] addr;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/ifetch_unit_inst_buf.sv
// ----------------------------------------------------------------------------
// ifetch_unit_inst_buf
// Single-entry instruction buffer presented to decode.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load         : capture i_inst/i_pc and mark the entry valid
//   i_clear        : invalidate the entry (data/pc are left as they were)
//   i_inst, i_pc   : instruction word and its PC
//   o_valid        : entry valid
//   o_inst, o_pc   : buffered instruction and PC
// ----------------------------------------------------------------------------
module ifetch_unit_inst_buf
    import ifetch_unit_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic          i_clear,
    input  logic [DW-1:0] i_inst,
    input  logic [AW-1:0] i_pc,
    output logic          o_valid,
    output logic [DW-1:0] o_inst,
    output logic [AW-1:0] o_pc
);

    logic          r_valid;
    logic [DW-1:0] r_inst;
    logic [AW-1:0] r_pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_inst  <= DW'(NOP);
            r_pc    <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_inst  <= i_inst;
            r_pc    <= i_pc;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_inst  = r_inst;
    assign o_pc    = r_pc;

endmodule

// File: rtl/ifetch_unit.sv
// ----------------------------------------------------------------------------
// ifetch_unit
// Fetches the instruction at the current PC over the imem req/ack bus,
// buffers it for decode (valid/ready) and returns the next PC to the pc
// register: redirect target, PC+4 on an accepted fetch, or PC when stalled.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | one cycle after reset release, no request
//   REQ     | request raised at {i_pc[AW-1:2],2'b00}, waiting for ack
//   HOLD    | instruction buffered, waiting for decode to take it
//
// Ports:
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_pc / o_next_pc : current PC in, next PC out (combinational)
//   imem             : instruction memory bus (master side)
//   i_redirect(_pc)  : branch/jump redirect pulse and target
//   o_inst_valid, o_inst, o_inst_pc, i_inst_ready : decode handshake
//   o_addr_err       : pulse, cycle after a misaligned redirect target
//   o_inst_count     : delivered-instruction counter, wraps
// ----------------------------------------------------------------------------
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [AW-1:0]    i_pc,
    output logic [AW-1:0]    o_next_pc,
    ifetch_unit_if.master    imem,
    input  logic             i_redirect,
    input  logic [AW-1:0]    i_redirect_pc,
    output logic             o_inst_valid,
    output logic [DW-1:0]    o_inst,
    output logic [AW-1:0]    o_inst_pc,
    input  logic             i_inst_ready,
    output logic             o_addr_err,
    output logic [CNT_W-1:0] o_inst_count
);

    localparam logic [AW-1:0] W_PC_INC = AW'(PC_INC);

    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic             r_kill;
    logic             w_kill_nxt;
    logic             r_addr_err;
    logic [CNT_W-1:0] r_count;

    logic             w_fire;
    logic             w_xfer;
    logic             w_buf_load;
    logic             w_buf_clear;

    // Ack that belongs to the live request; a killed request's ack is dropped.
    assign w_fire = (r_state == ST_REQ) && imem.ack && !r_kill;
    assign w_xfer = o_inst_valid && i_inst_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        w_buf_load  = 1'b0;
        w_buf_clear = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (imem.ack) begin
                    // Any ack ends the outstanding request; keep the data only
                    // if neither an earlier nor a same-cycle redirect hit it.
                    w_kill_nxt = 1'b0;
                    if (!r_kill && !i_redirect) begin
                        w_buf_load  = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end else if (i_redirect) begin
                    w_kill_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_xfer || i_redirect) begin
                    w_buf_clear = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_next_pc = i_pc;
        if (i_redirect) begin
            o_next_pc = {i_redirect_pc[AW-1:2], 2'b00};
        end else if (w_fire) begin
            o_next_pc = i_pc + W_PC_INC;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= i_redirect && is_misaligned(i_redirect_pc[1:0]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (w_xfer) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    ifetch_unit_inst_buf #(
        .AW (AW),
        .DW (DW)
    ) u_inst_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_buf_load),
        .i_clear (w_buf_clear),
        .i_inst  (imem.rdata),
        .i_pc    (i_pc),
        .o_valid (o_inst_valid),
        .o_inst  (o_inst),
        .o_pc    (o_inst_pc)
    );

    assign imem.req     = (r_state == ST_REQ);
    assign imem.addr    = {i_pc[AW-1:2], 2'b00};
    assign o_addr_err   = r_addr_err;
    assign o_inst_count = r_count;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    ifetch_unit_if #(.AW(32), .DW(32)) imem ();

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ready = 1'b1;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        addr_err;
    logic [15:0] inst_count;

    logic        pc_force = 1'b1;
    logic [31:0] pc_fv = 32'h0;
    int          mem_wait = 0;
    logic        spur = 1'b0;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] dq[$];

    ifetch_unit #(.AW(32), .DW(32), .CNT_W(16)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pc          (pc),
        .o_next_pc     (next_pc),
        .imem          (imem),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_inst_valid  (inst_valid),
        .o_inst        (inst),
        .o_inst_pc     (inst_pc),
        .i_inst_ready  (ready),
        .o_addr_err    (addr_err),
        .o_inst_count  (inst_count)
    );

    // pc register closing the loop
    always @(posedge clk) pc <= pc_force ? pc_fv : next_pc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // imem: samples the address when a request starts, answers after mem_wait cycles
    int          wcnt = 0;
    logic [31:0] lat_addr = 32'h0;
    initial begin
        imem.ack   = 1'b0;
        imem.rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                imem.ack = 1'b0;
                wcnt = 0;
            end else if (imem.ack) begin
                imem.ack = 1'b0;
                wcnt = 0;
            end else if (imem.req) begin
                if (wcnt == 0) lat_addr = imem.addr;
                if (wcnt >= mem_wait) begin
                    imem.ack = 1'b1;
                    imem.rdata = memf(lat_addr);
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                if (spur) begin
                    imem.ack = 1'b1;
                    imem.rdata = 32'hBAD0_BAD0;
                end
            end
        end
    end

    // Behavioural model: "started", "buffer full", "pending fetch was killed"
    logic        m_started, m_full, m_kill, m_err;
    logic [31:0] m_inst, m_ipc;
    logic [15:0] m_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started <= 1'b0; m_full <= 1'b0; m_kill <= 1'b0; m_err <= 1'b0;
            m_inst <= 32'h0; m_ipc <= 32'h0; m_cnt <= 16'h0;
        end else begin
            m_err <= redirect && (redirect_pc[1:0] != 2'b00);
            if (!m_started) begin
                m_started <= 1'b1;
            end else if (m_full) begin
                if (ready) m_cnt <= m_cnt + 16'd1;
                if (ready || redirect) m_full <= 1'b0;
            end else if (imem.ack) begin
                m_kill <= 1'b0;
                if (!m_kill && !redirect) begin
                    m_full <= 1'b1;
                    m_inst <= imem.rdata;
                    m_ipc  <= pc;
                end
            end else if (redirect) begin
                m_kill <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] e_next;
        if (redirect) e_next = {redirect_pc[31:2], 2'b00};
        else if (m_started && !m_full && imem.ack && !m_kill) e_next = pc + 32'd4;
        else e_next = pc;
        chk("next_pc", next_pc, e_next);
        chk("req", 32'(imem.req), 32'(m_started && !m_full));
        chk("addr", imem.addr, {pc[31:2], 2'b00});
        chk("valid", 32'(inst_valid), 32'(m_full));
        chk("inst", inst, m_inst);
        chk("inst_pc", inst_pc, m_ipc);
        chk("count", 32'(inst_count), 32'(m_cnt));
        chk("addr_err", 32'(addr_err), 32'(m_err));
        if (inst_valid && ready) begin
            dq.push_back(inst_pc);
            chk("inst_vs_mem", inst, memf(inst_pc));
        end
    end

    task automatic wait_dlv(input int n, input int budget);
        int k = 0;
        while (dq.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        chk("dlv_timeout", 32'(dq.size() >= n), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!inst_valid && k < budget) begin
            tick(1);
            k++;
        end
        chk("valid_timeout", 32'(inst_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(2);
        chk("rst_req", 32'(imem.req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_count", 32'(inst_count), 32'd0);
        chk("rst_inst", inst, 32'd0);
        rst_n = 1'b1;
        pc_force = 1'b0;

        // 1: zero-wait back-to-back fetches
        tick(6);
        mem_wait = 3;
        tick(1);
        chk("t1_count", 32'(inst_count), 32'd3);
        chk("t1_ndlv", 32'(dq.size()), 32'd3);
        chk("t1_pc0", dq[0], 32'h0);
        chk("t1_pc1", dq[1], 32'h4);
        chk("t1_pc2", dq[2], 32'h8);

        // 2: slow memory, request held
        for (int i = 0; i < 3; i++) begin
            chk("t2_req", 32'(imem.req), 32'd1);
            chk("t2_addr", imem.addr, 32'hC);
            chk("t2_next", next_pc, 32'hC);
            tick(1);
        end
        wait_dlv(4, 20);
        chk("t2_pc", dq[3], 32'hC);

        // 3: redirect while waiting, stale data dropped
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick(1);
        redirect = 1'b0;
        chk("t3_req", 32'(imem.req), 32'd1);
        chk("t3_addr", imem.addr, 32'h100);
        wait_dlv(5, 30);
        chk("t3_pc", dq[4], 32'h100);

        // 4: decode stalls, outputs frozen, spurious ack ignored, redirect
        ready = 1'b0;
        wait_valid(30);
        for (int i = 0; i < 5; i++) begin
            chk("t4_valid", 32'(inst_valid), 32'd1);
            chk("t4_ipc", inst_pc, 32'h104);
            chk("t4_inst", inst, memf(32'h104));
            chk("t4_next", next_pc, 32'h108);
            if (i == 2) begin
                @(negedge clk) spur = 1'b1;
                @(negedge clk) spur = 1'b0;
                @(posedge clk);
                #1;
            end else begin
                tick(1);
            end
        end
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick(1);
        redirect = 1'b0;
        chk("t4_inval", 32'(inst_valid), 32'd0);
        chk("t4_addr", imem.addr, 32'h40);
        wait_valid(30);
        chk("t4_fetch", inst_pc, 32'h40);
        chk("t4_fdata", inst, memf(32'h40));

        // 5: misaligned redirect, same cycle as a transfer
        ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h102;
        tick(1);
        redirect = 1'b0;
        chk("t5_err", 32'(addr_err), 32'd1);
        chk("t5_addr", imem.addr, 32'h100);
        chk("t5_valid", 32'(inst_valid), 32'd0);
        chk("t5_count", 32'(inst_count), 32'd6);
        tick(1);
        chk("t5_err_off", 32'(addr_err), 32'd0);
        wait_dlv(7, 30);
        chk("t5_pc40", dq[5], 32'h40);
        chk("t5_pc100", dq[6], 32'h100);
        chk("t5_count2", 32'(inst_count), 32'd7);

        // 6: reset during a request, restart near the top of the address space
        tick(1);
        rst_n = 1'b0;
        #1;
        chk("t6_req", 32'(imem.req), 32'd0);
        chk("t6_count", 32'(inst_count), 32'd0);
        pc_force = 1'b1;
        pc_fv = 32'hFFFF_FFFC;
        mem_wait = 0;
        tick(2);
        rst_n = 1'b1;
        pc_force = 1'b0;
        dq.delete();
        tick(1);
        #1;
        chk("t6_req2", 32'(imem.req), 32'd1);
        chk("t6_addr", imem.addr, 32'hFFFF_FFFC);
        chk("t6_wrap", next_pc, 32'h0);
        wait_dlv(2, 20);
        chk("t6_pc0", dq[0], 32'hFFFF_FFFC);
        chk("t6_pc1", dq[1], 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
